burst_line_adaptor: RTL
=======================

// Module: burst_line_adaptor
// PURPOSE
//  Parametrised bridge between the last-level cache (one LINE_W-bit line per request)
//  and main memory (BEATS = LINE_W/BURST_W bursts of BURST_W bits).
//  Successor to the fixed 256/64 adaptor: width-generic, latches request address/data,
//  optional critical-word-first read ordering, explicit IDLE/RD/WR/DONE FSM.
// PARAMETERS
//  LINE_W     256  cache line width, bits; integer multiple of BURST_W
//  BURST_W    64   memory beat width, bits; power of two >= 8
//  ADDR_W     32   byte address width
//  CRIT_FIRST 0    1: reads start at the beat holding address_i and wrap; 0: beat 0 first
//  (localparam BEATS = LINE_W/BURST_W, power of two >= 2; OFS = log2(BURST_W/8);
//   IDX = log2(BEATS))
// PORTS
//  clk        in   1        clock, all state on rising edge
//  reset_n    in   1        asynchronous active-low reset
//  line_i     in   LINE_W   write data from LLC, sampled with write_i in IDLE
//  line_o     out  LINE_W   assembled read line, valid when resp_o=1, held until next read
//  address_i  in   ADDR_W   LLC byte address, sampled in IDLE
//  read_i     in   1        LLC read request, level, held until resp_o
//  write_i    in   1        LLC write request, level, held until resp_o
//  resp_o     out  1        one-cycle completion pulse to LLC
//  busy_o     out  1        1 whenever state != IDLE
//  burst_i    in   BURST_W  memory read beat, valid when resp_i=1 during read
//  burst_o    out  BURST_W  memory write beat for current beat index
//  address_o  out  ADDR_W   latched request address to memory
//  read_o     out  1        memory read request, level
//  write_o    out  1        memory write request, level
//  resp_i     in   1        memory beat strobe: one beat transferred per high cycle
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; resp_o, busy_o, read_o, write_o = 0;
//   line_o, burst_o, address_o, beat counter = 0. Partial transfers are discarded.
//  IDLE: read_i=1 -> latch address, go RD, read_o=1 next cycle. Else write_i=1 -> latch
//   address and line_i, go WR, write_o=1 next cycle. read_i wins if both are high.
//   resp_i in IDLE is ignored.
//  Address: WR, and RD with CRIT_FIRST=0 -> address_o = address_i with low OFS+IDX bits
//   cleared. RD with CRIT_FIRST=1 -> address_o = address_i with low OFS bits cleared;
//   start beat s = address_i[OFS +: IDX].
//  RD: read_o held 1. Each resp_i=1 cycle writes burst_i into slot (s+k) mod BEATS of the
//   line buffer (s=0 when CRIT_FIRST=0), where k = beats already received; k increments.
//   Wait cycles (resp_i=0) between beats are legal and hold state. On beat BEATS-1:
//   read_o=0 next cycle, line_o <= full line including the final beat, go DONE.
//  WR: burst_o = latched_line[k*BURST_W +: BURST_W], driven registered while write_o=1;
//   updates the cycle after each resp_i=1. Beat order is always 0..BEATS-1.
//   On beat BEATS-1: write_o=0 next cycle, go DONE.
//  DONE: resp_o=1 for exactly one cycle, then IDLE. read_i/write_i ignored in DONE.
//   The LLC deasserts its request in the cycle it sees resp_o.
//  Latency, zero-wait memory: request seen at edge 0; read_o/write_o high from edge 1;
//   beats at edges 1..BEATS; resp_o high in cycle BEATS+1.
//  Counter: IDX-bit beat index, wraps mod BEATS; a separate done flag marks beat BEATS-1.
//   No overflow past BEATS beats.
//  Extra resp_i after the final beat, while read_o=write_o=0, is ignored.
//  address_o and line_i latch are stable for the whole transaction; changes on
//   address_i/line_i mid-transaction have no effect.
// TESTING
//  1 Read, default params, addr 0x1234_5678, beats A0..A3 no waits -> address_o=0x1234_5660,
//    line_o={A3,A2,A1,A0}, resp_o one cycle at cycle 5, read_o high cycles 1-4 only.
//  2 Write line {D3,D2,D1,D0}, resp_i pattern 1,0,0,1,1,0,1 -> burst_o presents D0..D3 in
//    order, write_o drops after 4th strobe, one resp_o pulse.
//  3 CRIT_FIRST=1, read addr 0x...48 (s=1), beats B0..B3 -> address_o=0x...48,
//    line_o={B2,B1,B0,B3}.
//  4 read_i and write_i high together in IDLE -> read performed, write_o stays 0.
//  5 reset_n low after 2 read beats -> all outputs 0 immediately; next read completes
//    cleanly with fresh data.
//  6 LINE_W=512, BURST_W=128: 4 beats; LINE_W=128, BURST_W=32: 4 beats; LINE_W=256,
//    BURST_W=32: 8 beats -> correct packing; resp_o after last beat.

Source files
------------

// File: rtl/burst_line_adaptor.sv
// Bridges one LLC line request to a sequence of memory bursts, with optional
// critical-word-first ordering for reads.
module burst_line_adaptor #(
   parameter int unsigned LINE_W     = 256,
   parameter int unsigned BURST_W    = 64,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned CRIT_FIRST = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic [ADDR_W-1:0]  address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   output logic               busy_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [ADDR_W-1:0]  address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);

   localparam int unsigned BEATS = LINE_W / BURST_W;
   localparam int unsigned OFS   = $clog2(BURST_W / 8);
   localparam int unsigned IDX   = $clog2(BEATS);

   localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << (OFS + IDX)) - ADDR_W'(1));
   localparam logic [ADDR_W-1:0] BEAT_MASK = ~((ADDR_W'(1) << OFS) - ADDR_W'(1));

   typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [LINE_W-1:0]  wline_q, wline_d;
   logic [LINE_W-1:0]  rline_q, rline_d;
   logic [LINE_W-1:0]  line_q, line_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [IDX-1:0]     beat_q, beat_d;
   logic [IDX-1:0]     start_q, start_d;
   logic               read_q, read_d;
   logic               write_q, write_d;
   logic               resp_q, resp_d;

   logic [IDX-1:0]     slot;
   logic [IDX-1:0]     beat_nxt;
   logic               last_beat;

   // Read slot wraps naturally in IDX bits, giving critical-word-first ordering.
   assign slot      = start_q + beat_q;
   assign beat_nxt  = beat_q + IDX'(1);
   assign last_beat = (beat_q == IDX'(BEATS - 1));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wline_d = wline_q;
      rline_d = rline_q;
      line_d  = line_q;
      burst_d = burst_q;
      beat_d  = beat_q;
      start_d = start_q;
      read_d  = read_q;
      write_d = write_q;
      resp_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            beat_d = '0;
            if (read_i) begin
               state_d = StRd;
               read_d  = 1'b1;
               if (CRIT_FIRST != 0) begin
                  addr_d  = address_i & BEAT_MASK;
                  start_d = address_i[OFS +: IDX];
               end else begin
                  addr_d  = address_i & LINE_MASK;
                  start_d = '0;
               end
            end else if (write_i) begin
               state_d = StWr;
               write_d = 1'b1;
               addr_d  = address_i & LINE_MASK;
               start_d = '0;
               wline_d = line_i;
               burst_d = line_i[BURST_W-1:0];
            end
         end

         StRd: begin
            if (resp_i) begin
               rline_d[slot*BURST_W +: BURST_W] = burst_i;
               beat_d = beat_nxt;
               if (last_beat) begin
                  read_d  = 1'b0;
                  line_d  = rline_d;
                  resp_d  = 1'b1;
                  state_d = StDone;
               end
            end
         end

         StWr: begin
            if (resp_i) begin
               beat_d = beat_nxt;
               if (last_beat) begin
                  write_d = 1'b0;
                  burst_d = '0;
                  resp_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  burst_d = wline_q[beat_nxt*BURST_W +: BURST_W];
               end
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wline_q <= '0;
         rline_q <= '0;
         line_q  <= '0;
         burst_q <= '0;
         beat_q  <= '0;
         start_q <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         resp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wline_q <= wline_d;
         rline_q <= rline_d;
         line_q  <= line_d;
         burst_q <= burst_d;
         beat_q  <= beat_d;
         start_q <= start_d;
         read_q  <= read_d;
         write_q <= write_d;
         resp_q  <= resp_d;
      end
   end

   assign line_o    = line_q;
   assign burst_o   = burst_q;
   assign address_o = addr_q;
   assign read_o    = read_q;
   assign write_o   = write_q;
   assign resp_o    = resp_q;
   assign busy_o    = (state_q != StIdle);

endmodule
